assoc_cache: RTL

Parametrised, truly set-associative, write-back/write-allocate data cache with LRU replacement and dirty-line eviction. It sits between a single-issue CPU port (32-bit word, byte strobes) and a burst-capable memory port. It generalises the fixed 64×4×128 B READY/REPLACE cache: sets, ways and line size are parameters, the way is chosen by lookup rather than address bits, and writes mark lines dirty and are written back on eviction.

---
 rtl/assoc_cache_if.sv | 34 +++
 rtl/assoc_cache.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/assoc_cache_if.sv
// CPU and memory-side signals of the set-associative cache.
// The slave modport belongs to the cache; the master modport belongs to
// whatever drives the CPU requests and answers the memory bursts.
interface assoc_cache_if;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_data_in;
  logic [3:0]  cpu_wstb;
  logic        cpu_re;
  logic        cpu_we;
  logic        cpu_ready;
  logic        cpu_ack;
  logic [31:0] cpu_data_out;
  logic        miss;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstb;
  logic        mem_last;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport slave (
    input  cpu_addr, cpu_data_in, cpu_wstb, cpu_re, cpu_we, mem_ready, mem_rdata,
    output cpu_ready, cpu_ack, cpu_data_out, miss,
           mem_req, mem_we, mem_addr, mem_wdata, mem_wstb, mem_last
  );

  modport master (
    output cpu_addr, cpu_data_in, cpu_wstb, cpu_re, cpu_we, mem_ready, mem_rdata,
    input  cpu_ready, cpu_ack, cpu_data_out, miss,
           mem_req, mem_we, mem_addr, mem_wdata, mem_wstb, mem_last
  );
endinterface

// File: rtl/assoc_cache.sv
// Set-associative write-back / write-allocate data cache with LRU replacement.
//
// state | meaning
// READY | idle, lookup of incoming CPU requests, hits served here
// WB    | burst of the dirty victim line back to memory
// FILL  | burst of the requested line from memory into the victim way
module assoc_cache #(
  parameter int NUM_SETS   = 64,
  parameter int NUM_WAYS   = 4,
  parameter int LINE_BYTES = 128
) (
  input  logic        clk,
  input  logic        reset_n,
  assoc_cache_if.slave bus
);
  localparam int WORDS  = LINE_BYTES / 4;
  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int IDX_W  = $clog2(NUM_SETS);
  localparam int TAG_W  = 32 - OFF_W - IDX_W;
  localparam int WORD_W = $clog2(WORDS);
  localparam int WAY_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;

  typedef logic [WAY_W-1:0]  way_t;
  typedef logic [IDX_W-1:0]  idx_t;
  typedef logic [WORD_W-1:0] word_t;
  typedef enum logic [1:0] {READY, WB, FILL} state_t;

  state_t state, state_nxt;

  logic [TAG_W-1:0] tag_arr   [NUM_SETS][NUM_WAYS];
  logic             valid_arr [NUM_SETS][NUM_WAYS];
  logic             dirty_arr [NUM_SETS][NUM_WAYS];
  logic [WAY_W-1:0] age_arr   [NUM_SETS][NUM_WAYS];
  logic [31:0]      data_arr  [NUM_SETS][NUM_WAYS][WORDS];

  logic [TAG_W-1:0] req_tag;
  idx_t             req_idx;
  word_t            req_word;
  logic [31:0]      req_data;
  logic [3:0]       req_wstb;
  logic             req_we;
  way_t             victim;
  word_t            beat;
  logic             ack_q;
  logic [31:0]      rdata_q;

  logic [TAG_W-1:0] a_tag;
  idx_t             a_idx;
  word_t            a_word;
  logic             req, hit, have_free, beat_last;
  way_t             hit_way, victim_sel;
  logic [31:0]      hit_word, fill_word;
  logic             touch_en;
  idx_t             touch_set;
  way_t             touch_way;
  logic             unused_addr;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  stb);
    merge_bytes = {stb[3] ? new_w[31:24] : old_w[31:24],
                   stb[2] ? new_w[23:16] : old_w[23:16],
                   stb[1] ? new_w[15:8]  : old_w[15:8],
                   stb[0] ? new_w[7:0]   : old_w[7:0]};
  endfunction

  assign a_tag       = bus.cpu_addr[31 -: TAG_W];
  assign a_idx       = bus.cpu_addr[OFF_W +: IDX_W];
  assign a_word      = bus.cpu_addr[2 +: WORD_W];
  assign unused_addr = ^bus.cpu_addr[1:0];
  assign req         = bus.cpu_re | bus.cpu_we;
  assign beat_last   = (beat == word_t'(WORDS - 1));
  assign hit_word    = data_arr[a_idx][hit_way][a_word];

  assign bus.cpu_ack      = ack_q;
  assign bus.cpu_data_out = rdata_q;
  assign bus.mem_wstb     = 4'b1111;

  // Tag lookup: first valid way whose tag matches the request.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (!hit && valid_arr[a_idx][way_t'(i)] && tag_arr[a_idx][way_t'(i)] == a_tag) begin
        hit     = 1'b1;
        hit_way = way_t'(i);
      end
    end
  end

  // Victim choice: lowest invalid way, else the least recently used one.
  always_comb begin
    victim_sel = '0;
    have_free  = 1'b0;
    for (int i = 0; i < NUM_WAYS; i++) begin
      if (!have_free && !valid_arr[a_idx][way_t'(i)]) begin
        have_free  = 1'b1;
        victim_sel = way_t'(i);
      end
    end
    if (!have_free) begin
      for (int i = 0; i < NUM_WAYS; i++) begin
        if (age_arr[a_idx][way_t'(i)] == WAY_W'(NUM_WAYS - 1)) victim_sel = way_t'(i);
      end
    end
  end

  // Fill beat data, with the pending CPU write merged into its target word.
  always_comb begin
    fill_word = bus.mem_rdata;
    if (req_we && beat == req_word) fill_word = merge_bytes(bus.mem_rdata, req_data, req_wstb);
  end

  // Which way becomes MRU this cycle: a hit, or the completed fill.
  always_comb begin
    touch_en  = 1'b0;
    touch_set = a_idx;
    touch_way = hit_way;
    if (state == READY && req && hit) begin
      touch_en = 1'b1;
    end else if (state == FILL && bus.mem_ready && beat_last) begin
      touch_en  = 1'b1;
      touch_set = req_idx;
      touch_way = victim;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) state <= READY;
    else          state <= state_nxt;
  end

  // Next state and memory-side outputs.
  always_comb begin
    state_nxt     = state;
    bus.cpu_ready = 1'b0;
    bus.miss      = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_last  = 1'b0;
    case (state)
      READY: begin
        bus.cpu_ready = 1'b1;
        if (req && !hit)
          state_nxt = (valid_arr[a_idx][victim_sel] && dirty_arr[a_idx][victim_sel]) ? WB : FILL;
      end
      WB: begin
        bus.miss      = 1'b1;
        bus.mem_req   = 1'b1;
        bus.mem_we    = 1'b1;
        bus.mem_addr  = {tag_arr[req_idx][victim], req_idx, beat, 2'b00};
        bus.mem_wdata = data_arr[req_idx][victim][beat];
        bus.mem_last  = beat_last;
        if (bus.mem_ready && beat_last) state_nxt = FILL;
      end
      FILL: begin
        bus.miss     = 1'b1;
        bus.mem_req  = 1'b1;
        bus.mem_addr = {req_tag, req_idx, beat, 2'b00};
        bus.mem_last = beat_last;
        if (bus.mem_ready && beat_last) state_nxt = READY;
      end
      default: state_nxt = READY;
    endcase
  end

  // Control: request latch, beat counter, line status, LRU ages, CPU response.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ack_q    <= 1'b0;
      rdata_q  <= '0;
      beat     <= '0;
      req_tag  <= '0;
      req_idx  <= '0;
      req_word <= '0;
      req_data <= '0;
      req_wstb <= '0;
      req_we   <= 1'b0;
      victim   <= '0;
      for (int s = 0; s < NUM_SETS; s++) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          valid_arr[idx_t'(s)][way_t'(w)] <= 1'b0;
          dirty_arr[idx_t'(s)][way_t'(w)] <= 1'b0;
          age_arr[idx_t'(s)][way_t'(w)]   <= WAY_W'(w);
        end
      end
    end else begin
      ack_q <= 1'b0;
      if (touch_en) begin
        for (int i = 0; i < NUM_WAYS; i++) begin
          if (age_arr[touch_set][way_t'(i)] < age_arr[touch_set][touch_way])
            age_arr[touch_set][way_t'(i)] <= age_arr[touch_set][way_t'(i)] + 1'b1;
        end
        age_arr[touch_set][touch_way] <= '0;
      end
      case (state)
        READY: begin
          if (req && hit) begin
            ack_q <= 1'b1;
            if (bus.cpu_we) dirty_arr[a_idx][hit_way] <= 1'b1;
            else            rdata_q <= hit_word;
          end else if (req) begin
            req_tag  <= a_tag;
            req_idx  <= a_idx;
            req_word <= a_word;
            req_data <= bus.cpu_data_in;
            req_wstb <= bus.cpu_wstb;
            req_we   <= bus.cpu_we;
            victim   <= victim_sel;
            beat     <= '0;
          end
        end
        WB: begin
          if (bus.mem_ready) beat <= beat_last ? '0 : beat + 1'b1;
        end
        FILL: begin
          if (bus.mem_ready) begin
            if (beat == req_word) rdata_q <= fill_word;
            if (beat_last) begin
              beat                       <= '0;
              valid_arr[req_idx][victim] <= 1'b1;
              dirty_arr[req_idx][victim] <= req_we;
              ack_q                      <= 1'b1;
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Line storage and tags; a beat landing in the reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (reset_n && state == READY && req && hit && bus.cpu_we)
      data_arr[a_idx][hit_way][a_word] <= merge_bytes(hit_word, bus.cpu_data_in, bus.cpu_wstb);
    if (reset_n && state == FILL && bus.mem_ready) begin
      data_arr[req_idx][victim][beat] <= fill_word;
      if (beat_last) tag_arr[req_idx][victim] <= req_tag;
    end
  end
endmodule
